// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch queue.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

    localparam int FETCH_XLEN = 32;

    typedef logic [FETCH_XLEN-1:0] insn_t;

    // Bus-side fetch state; kept as plain constants so older tools see fixed encodings.
    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t ST_IDLE  = 2'd0;
    localparam fetch_state_t ST_WAIT  = 2'd1;
    localparam fetch_state_t ST_DRAIN = 2'd2;

endpackage

// File: rtl/fetch_ring.sv
// Circular instruction storage: one write port, ISSUE_W read ports at rd_ptr+i.
// Latency: write visible on reads the cycle after the edge; reads are combinational.
// Backpressure: none; the parent guarantees writes only target free slots.
module fetch_ring
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 8,
    parameter int  ISSUE_W = 2,
    parameter int  XLEN    = FETCH_XLEN,
    localparam int PTR_W   = $clog2(DEPTH)
) (
    input  logic                           clk,
    input  logic                           wr_en,
    input  logic [PTR_W-1:0]               wr_ptr,
    input  logic [XLEN-1:0]                wr_data,
    input  logic [PTR_W-1:0]               rd_ptr,
    output logic [ISSUE_W-1:0][XLEN-1:0]   rd_data
);

    logic [XLEN-1:0] mem [DEPTH];

    // Storage write; no reset needed since the parent masks lanes beyond count.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Lane i reads head+i; pointer arithmetic wraps naturally at the power-of-two depth.
    for (genvar i = 0; i < ISSUE_W; i++) begin : g_rd
        logic [PTR_W-1:0] addr;
        assign addr       = rd_ptr + PTR_W'(i);
        assign rd_data[i] = mem[addr];
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: single-outstanding word fetch into a DEPTH ring, ISSUE_W lanes out.
// Latency: word acked in cycle N is visible on ins in cycle N+1; consume shifts the head at the edge.
// Backpressure: no new request while the ring is full; a redirect drains any in-flight transfer.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int              DEPTH    = 8,
    parameter int              ISSUE_W  = 2,
    parameter int              XLEN     = FETCH_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    localparam int             CW       = $clog2(ISSUE_W + 1),
    localparam int             PTR_W    = $clog2(DEPTH),
    localparam int             CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CW-1:0]                 consume,
    input  logic                          redirect,
    input  logic [XLEN-1:0]               redirect_pc,
    output logic [ISSUE_W-1:0]            ins_valid,
    output logic [ISSUE_W-1:0][XLEN-1:0]  ins,
    output logic [XLEN-1:0]               ins_pc,
    output logic                          mem_req,
    output logic [XLEN-1:0]               mem_addr,
    input  logic                          mem_ack,
    input  logic [XLEN-1:0]               mem_rdata
);

    fetch_state_t                       state;
    logic [CNT_W-1:0]                   count;
    logic [PTR_W-1:0]                   rd_ptr;
    logic [PTR_W-1:0]                   wr_ptr;
    logic [XLEN-1:0]                    head_pc;
    logic [XLEN-1:0]                    fetch_pc;
    logic [XLEN-1:0]                    req_addr;
    logic                               xfer_busy;
    logic                               can_issue;
    logic                               wr_en;
    logic [CNT_W-1:0]                   cons_req;
    logic [CNT_W-1:0]                   cons_eff;
    logic [ISSUE_W-1:0][XLEN-1:0]       ring_dat;

    // A transfer is in flight whenever we are not idle; the bus cannot abort it.
    assign xfer_busy = (state != ST_IDLE);
    assign can_issue = (count < CNT_W'(DEPTH)) && !redirect;

    // In IDLE the request is combinational so a same-cycle ack completes without visiting WAIT.
    assign mem_req  = !rst && (xfer_busy || can_issue);
    assign mem_addr = xfer_busy ? req_addr : fetch_pc;

    // Data lands only for live transfers; drained or redirect-cycle acks are dropped.
    assign wr_en  = mem_req && mem_ack && !redirect && (state != ST_DRAIN);
    assign wr_ptr = rd_ptr + PTR_W'(count);

    // Over-consumption is clamped so count can never underflow.
    assign cons_req = CNT_W'(consume);
    assign cons_eff = (cons_req > count) ? count : cons_req;

    // Occupancy and head pointer; redirect empties the queue and overrides write/consume.
    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= '0;
            rd_ptr <= '0;
        end else if (redirect) begin
            count  <= '0;
        end else begin
            count  <= count + CNT_W'(wr_en) - cons_eff;
            rd_ptr <= rd_ptr + PTR_W'(cons_eff);
        end
    end

    // Program counters: head tracks lane 0, fetch_pc is the next word to request.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_pc  <= RESET_PC;
            fetch_pc <= RESET_PC;
        end else if (redirect) begin
            head_pc  <= redirect_pc;
            fetch_pc <= redirect_pc;
        end else begin
            head_pc <= head_pc + (XLEN'(cons_eff) << 2);
            if (wr_en) begin
                fetch_pc <= fetch_pc + XLEN'(4);
            end
        end
    end

    // Bus FSM: IDLE issues, WAIT holds for a live word, DRAIN swallows a stale one.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            req_addr <= RESET_PC;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mem_req && !mem_ack) begin
                        state    <= ST_WAIT;
                        req_addr <= fetch_pc;
                    end
                end
                ST_WAIT: begin
                    if (mem_ack) begin
                        state <= ST_IDLE;
                    end else if (redirect) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (mem_ack) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    fetch_ring #(
        .DEPTH   (DEPTH),
        .ISSUE_W (ISSUE_W),
        .XLEN    (XLEN)
    ) u_ring (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_ptr  (wr_ptr),
        .wr_data (mem_rdata),
        .rd_ptr  (rd_ptr),
        .rd_data (ring_dat)
    );

    // Lanes beyond the occupied count are forced to zero so nothing stale leaks out.
    for (genvar i = 0; i < ISSUE_W; i++) begin : g_lane
        assign ins_valid[i] = (count > CNT_W'(i));
        assign ins[i]       = ins_valid[i] ? ring_dat[i] : '0;
    end

    assign ins_pc = head_pc;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue against a queue-of-addresses reference model.
// Latency: n/a.
// Backpressure: bench memory acks after a programmable number of wait cycles.
module tb_fetch_queue;

    localparam int          DEPTH    = 8;
    localparam int          ISSUE_W  = 2;
    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic                         clk = 1'b0;
    logic                         rst;
    logic [1:0]                   consume;
    logic                         redirect;
    logic [XLEN-1:0]              redirect_pc;
    logic [ISSUE_W-1:0]           ins_valid;
    logic [ISSUE_W-1:0][XLEN-1:0] ins;
    logic [XLEN-1:0]              ins_pc;
    logic                         mem_req;
    logic [XLEN-1:0]              mem_addr;
    logic                         mem_ack;
    logic [XLEN-1:0]              mem_rdata;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Bus responder: ack once the request has waited lat cycles (lat = 0 is combinational).
    int lat  = 0;
    int wcnt = 0;

    // Reference model state: word addresses currently queued, plus PCs and bus view.
    logic [31:0] mq[$];
    logic [31:0] m_head, m_fetch, m_addr;
    bit          m_busy, m_stale;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    assign mem_ack   = mem_req && (wcnt >= lat);
    assign mem_rdata = mem_word(mem_addr);

    always @(posedge clk) begin
        if (rst || !mem_req || mem_ack) wcnt <= 0;
        else                            wcnt <= wcnt + 1;
    end

    fetch_queue #(
        .DEPTH    (DEPTH),
        .ISSUE_W  (ISSUE_W),
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .consume     (consume),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .ins_valid   (ins_valid),
        .ins         (ins),
        .ins_pc      (ins_pc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata)
    );

    // One clock of stimulus: drive, compare against the model mid-cycle, then advance the model.
    task automatic step(input int cons, input bit redir, input logic [31:0] rpc);
        bit          e_req, ack_s, e_v;
        logic [31:0] e_addr, e_lane, xa;
        assert (cons <= mq.size())
            else $error("consume %0d exceeds occupancy %0d", cons, mq.size());
        consume     = 2'(cons);
        redirect    = redir;
        redirect_pc = rpc;
        @(negedge clk);
        cyc++;
        e_req  = m_busy || (!redir && mq.size() < DEPTH);
        e_addr = m_busy ? m_addr : m_fetch;
        total++;
        if (mem_req !== e_req) begin
            bad++;
            $display("FAIL mem_req cyc=%0d got=%b want=%b", cyc, mem_req, e_req);
        end
        total++;
        if (mem_addr !== e_addr) begin
            bad++;
            $display("FAIL mem_addr cyc=%0d got=%h want=%h", cyc, mem_addr, e_addr);
        end
        total++;
        if (ins_pc !== m_head) begin
            bad++;
            $display("FAIL ins_pc cyc=%0d got=%h want=%h", cyc, ins_pc, m_head);
        end
        for (int i = 0; i < ISSUE_W; i++) begin
            e_v    = (i < mq.size());
            e_lane = e_v ? mem_word(mq[i]) : 32'h0;
            total++;
            if (ins_valid[i] !== e_v || ins[i] !== e_lane) begin
                bad++;
                $display("FAIL lane%0d cyc=%0d got=%b/%h want=%b/%h",
                         i, cyc, ins_valid[i], ins[i], e_v, e_lane);
            end
        end
        ack_s = e_req && (wcnt >= lat);
        @(posedge clk);
        xa = m_busy ? m_addr : m_fetch;
        if (redir) begin
            if (e_req && !ack_s) begin
                m_busy  = 1'b1;
                m_stale = 1'b1;
                m_addr  = xa;
            end else begin
                m_busy  = 1'b0;
                m_stale = 1'b0;
            end
            mq.delete();
            m_head  = rpc;
            m_fetch = rpc;
        end else begin
            for (int k = 0; k < cons; k++) void'(mq.pop_front());
            m_head = m_head + 32'(cons) * 4;
            if (e_req && ack_s) begin
                if (!m_stale) begin
                    mq.push_back(xa);
                    m_fetch = m_fetch + 4;
                end
                m_busy  = 1'b0;
                m_stale = 1'b0;
            end else if (e_req) begin
                m_busy = 1'b1;
                m_addr = xa;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; consume = '0; redirect = 1'b0; redirect_pc = '0;
        @(posedge clk);
        @(negedge clk);
        total++; if (ins_valid !== 2'b00) begin bad++; $display("FAIL rst_valid got=%b want=00", ins_valid); end
        total++; if (ins !== '0) begin bad++; $display("FAIL rst_ins got=%h want=0", ins); end
        total++; if (ins_pc !== RESET_PC) begin bad++; $display("FAIL rst_pc got=%h want=%h", ins_pc, RESET_PC); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b want=0", mem_req); end
        total++; if (mem_addr !== RESET_PC) begin bad++; $display("FAIL rst_addr got=%h want=%h", mem_addr, RESET_PC); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete();
        m_head = RESET_PC; m_fetch = RESET_PC; m_addr = RESET_PC;
        m_busy = 1'b0; m_stale = 1'b0;
    endtask

    task automatic test_streaming();
        lat = 0;
        repeat (12) step(0, 1'b0, 32'h0);
        total++; if (ins_valid !== 2'b11) begin bad++; $display("FAIL stream_valid got=%b want=11", ins_valid); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL stream_full_req got=%b want=0", mem_req); end
    endtask

    task automatic test_dual_issue();
        lat = 3;
        repeat (40) step(min2(2, mq.size()), 1'b0, 32'h0);
    endtask

    task automatic test_single_slide();
        int n;
        lat = 0;
        step(0, 1'b1, 32'h10);
        n = 0;
        while (mq.size() < 2 && n < 20) begin
            step(0, 1'b0, 32'h0);
            n++;
        end
        total++; if (mq.size() < 2) begin bad++; $display("FAIL slide_fill_timeout got=%0d want=2", mq.size()); end
        step(1, 1'b0, 32'h0);
        total++; if (ins[0] !== mem_word(32'h14)) begin bad++; $display("FAIL slide_lane0 got=%h want=%h", ins[0], mem_word(32'h14)); end
        total++; if (ins_pc !== 32'h14) begin bad++; $display("FAIL slide_pc got=%h want=00000014", ins_pc); end
    endtask

    task automatic test_redirect_mid();
        int n;
        lat = 3;
        n = 0;
        while (!m_busy && n < 30) begin
            step(min2(2, mq.size()), 1'b0, 32'h0);
            n++;
        end
        total++; if (!m_busy) begin bad++; $display("FAIL mid_wait_timeout got=0 want=1"); end
        step(0, 1'b1, 32'h100);
        total++; if (ins_valid !== 2'b00) begin bad++; $display("FAIL mid_flush_valid got=%b want=00", ins_valid); end
        n = 0;
        while (mq.size() == 0 && n < 20) begin
            step(0, 1'b0, 32'h0);
            n++;
        end
        total++; if (ins_pc !== 32'h100) begin bad++; $display("FAIL mid_pc got=%h want=00000100", ins_pc); end
        total++; if (ins[0] !== mem_word(32'h100)) begin bad++; $display("FAIL mid_word got=%h want=%h", ins[0], mem_word(32'h100)); end
    endtask

    task automatic test_full_wrap();
        lat = 0;
        repeat (10) step(0, 1'b0, 32'h0);
        repeat (20) step(1, 1'b0, 32'h0);
    endtask

    task automatic test_redirect_ack();
        int n;
        lat = 2;
        n = 0;
        while (!(m_busy && wcnt == lat) && n < 30) begin
            step(min2(2, mq.size()), 1'b0, 32'h0);
            n++;
        end
        total++; if (!(m_busy && wcnt == lat)) begin bad++; $display("FAIL rdack_setup_timeout got=%0d want=%0d", wcnt, lat); end
        step(0, 1'b1, 32'h200);
        redirect = 1'b0;
        #1;
        total++; if (ins_valid !== 2'b00) begin bad++; $display("FAIL rdack_valid got=%b want=00", ins_valid); end
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h200) begin
            bad++; $display("FAIL rdack_req got=%b/%h want=1/00000200", mem_req, mem_addr);
        end
        repeat (8) step(min2(1, mq.size()), 1'b0, 32'h0);
    endtask

    task automatic test_random();
        int          c;
        bit          r;
        logic [31:0] pc;
        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 9) == 0) lat = $urandom_range(0, 3);
            r  = ($urandom_range(0, 31) == 0);
            pc = 32'($urandom_range(0, 4095)) << 2;
            c  = $urandom_range(0, min2(2, mq.size()));
            step(c, r, pc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_streaming();
        test_dual_issue();
        test_single_slide();
        test_redirect_mid();
        test_full_wrap();
        test_redirect_ack();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction prefetch queue feeding the dual-issue scheduler. It fetches sequential 32-bit words from instruction memory over a single-outstanding req/ack bus into a DEPTH-entry circular buffer. It presents up to ISSUE_W instructions per cycle with explicit per-lane valid bits. It retires 0..ISSUE_W of them per cycle under scheduler control and flushes and refetches on a control-flow redirect.

## Interface
Parameters:
- DEPTH, 8: queue entries; power of two, at least ISSUE_W.
- ISSUE_W, 2: instruction lanes presented per cycle.
- XLEN, 32: instruction and address width.
- RESET_PC, 32'h0: fetch address after reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset; one clock, synchronous, active-high.
- consume  in  $clog2(ISSUE_W+1)  instructions retired this cycle; 0 = freeze.
- redirect  in  1  flush the queue and refetch from redirect_pc.
- redirect_pc  in  XLEN  new fetch address; word-aligned.
- ins_valid  out  ISSUE_W  bit i set when lane i holds a valid instruction.
- ins  out  ISSUE_W×XLEN  lane i = queue entry head+i.
- ins_pc  out  XLEN  PC of lane 0; lane i PC = ins_pc + 4i.
- mem_req  out  1  bus request; held until mem_ack.
- mem_addr  out  XLEN  word address; stable while mem_req is high.
- mem_ack  in  1  transfer complete; mem_rdata valid this cycle.
- mem_rdata  in  XLEN  fetched instruction.

## Operation
State machine with three states:
- IDLE: assert mem_req when count < DEPTH and redirect = 0; move to WAIT. If mem_ack arrives in the same cycle, complete immediately and stay in IDLE.
- WAIT: hold mem_req and mem_addr. On mem_ack, write mem_rdata at wr_ptr, add 4 to fetch_pc, return to IDLE. Redirect without ack goes to DRAIN.
- DRAIN: hold mem_req until mem_ack, discard the data, return to IDLE. The bus cannot abort a transfer.

Queue update rules:
- count_next = count + write − consume.
- A write is always accepted: a request only issues when count < DEPTH and only one transfer is outstanding.
- consume > count is a protocol violation; the bench asserts on it. RTL clamps consume to count.
- ins_valid[i] = (count > i). Invalid lanes drive 0.
- ins_pc increments by 4·consume.
- Pointers wrap modulo DEPTH.

Redirect:
- Redirect beats write and consume in the same cycle.
- Effects: count ← 0, head_pc ← redirect_pc, fetch_pc ← redirect_pc.
- Any mem_ack in the redirect cycle is discarded.
- If a transfer was outstanding without ack, go to DRAIN. Otherwise go to IDLE and issue the new request the next cycle.

Reset values: ins_valid = 0, ins = 0, ins_pc = RESET_PC, mem_req = 0, mem_addr = RESET_PC, state IDLE, count = 0.

## Timing
- First mem_req is high in the first cycle after rst deasserts.
- Ack-to-visible latency is 1 cycle: data acked in cycle N appears in ins in cycle N+1.
- Maximum throughput is 1 word per cycle when mem_ack is combinational.
- consume takes effect at the edge. The new head is presented the next cycle.
- Full: count = DEPTH deasserts request issue. A consume in cycle N allows mem_req in cycle N+1.
- Simultaneous write and consume at count = DEPTH−1 is legal; net count = DEPTH−consume.
- Redirect in cycle N with no outstanding transfer: mem_req with mem_addr = redirect_pc in cycle N+1.
- Redirect while a transfer is outstanding: the new request issues one cycle after the draining ack.

## Structure
- Package fetch_pkg holds the state enum (IDLE, WAIT, DRAIN), the XLEN default and the instruction word type.
- Sub-module fetch_ring: DEPTH×XLEN storage with one write port and ISSUE_W read ports at head+i modulo DEPTH.
- The parent module holds the FSM, the pointers, count and the PC registers.

## Test plan
- **Reset and streaming:** rst for 2 cycles, memory acks combinationally, consume = 0. Expected: mem_addr runs 0, 4, 8, … and ins_valid reaches 2'b11. mem_req drops when count = 8 (DEPTH = 8).
- **Steady dual issue:** consume = 2 every cycle with 3-cycle memory latency. Expected: ins_pc advances by 8 per consume. Lanes never show stale or duplicated words. count never underflows.
- **Single-slide dependency:** consume = 1 with lanes holding words at 0x10 and 0x14. Expected next cycle: lane0 = word at 0x14, ins_pc = 0x14.
- **Redirect mid-transfer:** redirect_pc = 0x100 while in WAIT, ack arrives 2 cycles later. Expected: the stale word is dropped, ins_valid = 0 until the word at 0x100 arrives, and the next mem_addr is 0x100.
- **Full plus wrap:** fill to 8 entries, consume 1 per cycle for 20 cycles. Expected: pointers wrap, ins_pc stays contiguous, and the same-cycle write and consume at count = 7 keeps data in order.
- **Simultaneous redirect and ack:** redirect and mem_ack in the same cycle. Expected: data discarded, state IDLE, new request to redirect_pc next cycle.
